sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Memory-side stage directly downstream of the MMU; consumes its physical word address, memory op, byte offset and store data; drives one shared 1M x 32 asynchronous SRAM.
- Arbitrates instruction fetch against data access (data wins) through a multi-cycle FSM.
- Returns load_data/load_inst/success to the MMU, which forwards them to MEM/IF; stall_o freezes the pipeline while a data access is in flight.

Parameters:
- RD_WAIT, 1, extra cycles the read address is held before data is sampled (0..3).
- WR_PULSE, 1, cycles we_n is held low (1..3).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ramOp_i  in  4  MEM_* op code from the MMU (shared defines)
- dataAddr_i  in  20  physical word address, data side
- instAddr_i  in  20  physical word address, fetch side
- storeData_i  in  32  unaligned store data (low bits valid)
- bytes_i  in  2  byte offset within the word
- load_data_o  out  32  extended load result
- load_inst_o  out  32  fetched instruction
- success_o  out  1  one-cycle pulse: data op complete
- stall_o  out  1  pipeline hold request
- sram_data  inout  32  SRAM data bus
- sram_addr  out  20  SRAM address
- sram_be_n  out  4  byte enables, active low
- sram_ce_n / sram_oe_n / sram_we_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset (sync, rst=1 at a clk edge) forces:
  - state IDLE
  - load_data_o = 0, load_inst_o = 0, success_o = 0, stall_o = 0
  - ce_n = oe_n = we_n = 1, be_n = 4'hF, sram_addr = 0
  - sram_data tri-stated
- Reset mid-operation aborts the access; we_n is released on the same edge.
- States: IDLE, FETCH, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - Load op (LW/LB/LBU/LH/LHU) -> RD.
  - Store op (SW/SH/SB) -> WR_SETUP.
  - NOP -> FETCH.
  - ramOp_i, dataAddr_i, bytes_i and storeData_i are captured at acceptance; later input changes are ignored until DONE.
- FETCH:
  - addr = instAddr_i, ce_n = 0, oe_n = 0, be_n = 0.
  - After RD_WAIT+1 cycles, sram_data is latched into load_inst_o; return to IDLE.
  - Fetch latency is RD_WAIT+1 cycles.
  - A data op arriving during FETCH is taken in IDLE after the fetch completes; a fetch is never aborted.
- RD:
  - addr = captured data address, oe_n = 0, be_n = 0.
  - After RD_WAIT+1 cycles, the word is latched and extended -> DONE.
- Load extension (byte offset b):
  - LB: sign-extended byte b.
  - LBU: zero-extended byte b.
  - LH: sign-extended half selected by b[1].
  - LHU: zero-extended half selected by b[1].
  - LW: full word.
  - b[0] is ignored for halves; misalignment is trapped upstream.
- Write: data is driven on sram_data from WR_SETUP through WR_HOLD; the bus is tri-stated in every other state.
  - SB: byte replicated to all lanes; be_n = ~(1<<b).
  - SH: half replicated; be_n = 4'b1100 if b[1] = 0, else 4'b0011.
  - SW: be_n = 0.
  - WR_SETUP (1 cycle): addr, data and be_n stable, we_n = 1.
  - WR_PULSE (WR_PULSE cycles): we_n = 0.
  - WR_HOLD (1 cycle): we_n = 1, data still driven -> DONE.
- DONE: success_o = 1 for exactly this cycle; stall_o = 0; -> IDLE.
- stall_o:
  - Rises combinationally in IDLE when a data op is present.
  - Stays high through RD/WR states; low in DONE.
  - Also high while in FETCH with a data op pending.
- load_data_o holds its value until the next load completes.
- load_inst_o holds its value until the next fetch completes.

Decomposition:
- MEM_* op codes and the load/store classification already live in the shared defines.
- Add to the shared defines: SRAM FSM state encodings and a MEM_IS_LOAD / MEM_IS_STORE macro pair.
- One sub-module: sram_lane_fmt. It is combinational and performs load extension, store replication and be_n generation from op and offset.

Test Plan:
- Reset asserted mid-WR_PULSE -> next edge: we_n = 1, sram_data = Z, stall_o = 0, success_o = 0.
- SW addr 0x00010, data 0xDEADBEEF, then LW same addr (RD_WAIT=1) -> be_n = 0, one we_n pulse; load_data_o = 0xDEADBEEF; success_o pulses once per op.
- SB 0x5A at b = 2 into word 0x11223344, then LB/LBU b = 2 -> be_n = 4'b1011; word becomes 0x115A3344; LB = 0x0000005A. With 0xA5 instead: LB = 0xFFFFFFA5, LBU = 0x000000A5.
- SH 0x8001 at b = 2, then LH/LHU -> be_n = 4'b0011; LH = 0xFFFF8001, LHU = 0x00008001.
- NOP stream with instAddr 0x00004 holding 0x24020001 -> load_inst_o = 0x24020001 two cycles after FETCH entry; stall_o stays 0.
- Load arriving during FETCH -> fetch completes first; stall_o is high until DONE; load_data_o is correct and load_inst_o is not corrupted.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared definitions for the memory-side SRAM controller:
//     - MEM_* op codes as issued by the MMU
//     - load/store classification helpers
//     - SRAM sequencing FSM state encoding
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LBU = 4'd2;
    localparam logic [3:0] MEM_LH  = 4'd3;
    localparam logic [3:0] MEM_LHU = 4'd4;
    localparam logic [3:0] MEM_LW  = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_RD       = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5,
        ST_DONE     = 3'd6
    } sram_state_e;

    function automatic logic mem_is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic mem_is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if
//   MMU <-> SRAM controller bundle. Suffixes are from the controller's view.
//     ramOp_i      MEM_* op code
//     dataAddr_i   physical word address, data side
//     instAddr_i   physical word address, fetch side
//     storeData_i  unaligned store data (low bits valid)
//     bytes_i      byte offset within the word
//     load_data_o  extended load result
//     load_inst_o  fetched instruction
//     success_o    one-cycle pulse when a data op completes
//     stall_o      pipeline hold request
// ---------------------------------------------------------------------------
interface sram_ctrl_if;

    logic [3:0]  ramOp_i;
    logic [19:0] dataAddr_i;
    logic [19:0] instAddr_i;
    logic [31:0] storeData_i;
    logic [1:0]  bytes_i;
    logic [31:0] load_data_o;
    logic [31:0] load_inst_o;
    logic        success_o;
    logic        stall_o;

    modport master (
        output ramOp_i, dataAddr_i, instAddr_i, storeData_i, bytes_i,
        input  load_data_o, load_inst_o, success_o, stall_o
    );

    modport slave (
        input  ramOp_i, dataAddr_i, instAddr_i, storeData_i, bytes_i,
        output load_data_o, load_inst_o, success_o, stall_o
    );

endinterface

// File: rtl/sram_lane_fmt.sv
// ---------------------------------------------------------------------------
// sram_lane_fmt
//   Combinational byte-lane formatting for the SRAM controller.
//     op_i          MEM_* op code
//     bytes_i       byte offset within the word
//     store_data_i  raw store data (low bits valid)
//     rdata_i       word read from the SRAM
//     load_data_o   sign/zero-extended load result
//     wdata_o       store data replicated onto the lanes
//     be_n_o        active-low byte enables for the store
// ---------------------------------------------------------------------------
module sram_lane_fmt
    import sram_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  bytes_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_n_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (bytes_i)
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            2'd3:    byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        // Halves ignore bytes_i[0]; misaligned halves never reach this stage.
        half_sel = bytes_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        load_data_o = rdata_i;
        case (op_i)
            MEM_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: load_data_o = {24'h0, byte_sel};
            MEM_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: load_data_o = {16'h0, half_sel};
            default: load_data_o = rdata_i;
        endcase

        wdata_o = store_data_i;
        be_n_o  = 4'hF;
        case (op_i)
            MEM_SB: begin
                wdata_o = {4{store_data_i[7:0]}};
                be_n_o  = ~(4'b0001 << bytes_i);
            end
            MEM_SH: begin
                wdata_o = {2{store_data_i[15:0]}};
                be_n_o  = bytes_i[1] ? 4'b0011 : 4'b1100;
            end
            MEM_SW: begin
                wdata_o = store_data_i;
                be_n_o  = 4'b0000;
            end
            default: begin
                wdata_o = store_data_i;
                be_n_o  = 4'hF;
            end
        endcase
    end

endmodule

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//   Memory-side stage behind the MMU driving one shared 1M x 32 async SRAM.
//   Instruction fetch and data access share the SRAM; data wins in IDLE.
//     clk, rst            system clock, synchronous active-high reset
//     bus (slave)         MMU-side op/address/data, results, stall
//     sram_data           bidirectional SRAM data bus
//     sram_addr           SRAM word address
//     sram_be_n           byte enables (active low)
//     sram_ce_n/oe_n/we_n SRAM strobes (active low)
//
//   state       | meaning
//   ------------+-------------------------------------------------
//   IDLE        | no access; accept data op, otherwise start fetch
//   FETCH       | instruction read, RD_WAIT+1 cycles
//   RD          | data read, RD_WAIT+1 cycles, then extend
//   WR_SETUP    | addr/data/be_n stable, we_n high
//   WR_PULSE    | we_n low for WR_PULSE cycles
//   WR_HOLD     | we_n high, data still driven
//   DONE        | success pulse, stall released
// ---------------------------------------------------------------------------
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic        clk,
    input  logic        rst,
    sram_ctrl_if.slave  bus,
    inout  wire  [31:0] sram_data,
    output logic [19:0] sram_addr,
    output logic [3:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam logic [1:0] RD_CNT = 2'(RD_WAIT);
    localparam logic [1:0] WR_CNT = 2'(WR_PULSE - 1);

    sram_state_e state_q;
    logic [1:0]  cnt_q;
    logic [3:0]  op_q;
    logic [1:0]  bytes_q;
    logic [31:0] wdata_q;
    logic        drive_q;
    logic [19:0] addr_q;
    logic [3:0]  be_n_q;
    logic        ce_n_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic [31:0] load_data_q;
    logic [31:0] load_inst_q;
    logic        success_q;

    logic        data_pend;
    logic        stall_d;
    logic [3:0]  fmt_op;
    logic [1:0]  fmt_bytes;
    logic [31:0] fmt_load;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be_n;

    // In IDLE the formatter sees the live request so store lanes can be
    // registered at acceptance; afterwards it sees the captured op.
    assign fmt_op    = (state_q == ST_IDLE) ? bus.ramOp_i : op_q;
    assign fmt_bytes = (state_q == ST_IDLE) ? bus.bytes_i : bytes_q;

    sram_lane_fmt u_lane_fmt (
        .op_i         (fmt_op),
        .bytes_i      (fmt_bytes),
        .store_data_i (bus.storeData_i),
        .rdata_i      (sram_data),
        .load_data_o  (fmt_load),
        .wdata_o      (fmt_wdata),
        .be_n_o       (fmt_be_n)
    );

    assign data_pend = mem_is_load(bus.ramOp_i) || mem_is_store(bus.ramOp_i);

    always_comb begin
        stall_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_FETCH:                            stall_d = data_pend;
            ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD:  stall_d = 1'b1;
            default:                                      stall_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            op_q        <= MEM_NOP;
            bytes_q     <= 2'd0;
            wdata_q     <= 32'h0;
            drive_q     <= 1'b0;
            addr_q      <= 20'h0;
            be_n_q      <= 4'hF;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            load_data_q <= 32'h0;
            load_inst_q <= 32'h0;
            success_q   <= 1'b0;
        end else begin
            success_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_is_load(bus.ramOp_i)) begin
                        state_q <= ST_RD;
                        op_q    <= bus.ramOp_i;
                        bytes_q <= bus.bytes_i;
                        addr_q  <= bus.dataAddr_i;
                        be_n_q  <= 4'h0;
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
                        cnt_q   <= RD_CNT;
                    end else if (mem_is_store(bus.ramOp_i)) begin
                        state_q <= ST_WR_SETUP;
                        op_q    <= bus.ramOp_i;
                        bytes_q <= bus.bytes_i;
                        addr_q  <= bus.dataAddr_i;
                        wdata_q <= fmt_wdata;
                        be_n_q  <= fmt_be_n;
                        drive_q <= 1'b1;
                        ce_n_q  <= 1'b0;
                    end else begin
                        state_q <= ST_FETCH;
                        addr_q  <= bus.instAddr_i;
                        be_n_q  <= 4'h0;
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
                        cnt_q   <= RD_CNT;
                    end
                end
                ST_FETCH: begin
                    if (cnt_q == 2'd0) begin
                        load_inst_q <= sram_data;
                        be_n_q      <= 4'hF;
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_RD: begin
                    if (cnt_q == 2'd0) begin
                        load_data_q <= fmt_load;
                        be_n_q      <= 4'hF;
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        success_q   <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_WR_SETUP: begin
                    we_n_q  <= 1'b0;
                    cnt_q   <= WR_CNT;
                    state_q <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (cnt_q == 2'd0) begin
                        we_n_q  <= 1'b1;
                        state_q <= ST_WR_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_WR_HOLD: begin
                    drive_q   <= 1'b0;
                    be_n_q    <= 4'hF;
                    ce_n_q    <= 1'b1;
                    success_q <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sram_data = drive_q ? wdata_q : 32'hzzzz_zzzz;
    assign sram_addr = addr_q;
    assign sram_be_n = be_n_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;

    assign bus.load_data_o = load_data_q;
    assign bus.load_inst_o = load_inst_q;
    assign bus.success_o   = success_q;
    assign bus.stall_o     = stall_d;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_ctrl_if bus();

    wire  [31:0] sram_data;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    sram_ctrl #(.RD_WAIT(1), .WR_PULSE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_data (sram_data),
        .sram_addr (sram_addr),
        .sram_be_n (sram_be_n),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n)
    );

    // Async SRAM model: 64 words, write on the rising edge of we_n.
    logic [31:0] mem [0:63];
    assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 32'hzzzz_zzzz;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h2402_0001;
        mem[32] = 32'h1122_3344;
        forever begin
            @(posedge sram_we_n);
            if (!sram_ce_n) begin
                for (int l = 0; l < 4; l++)
                    if (!sram_be_n[l]) mem[sram_addr[5:0]][8*l +: 8] = sram_data[8*l +: 8];
            end
        end
    end

    int         we_pulses = 0;
    int         we_low_cyc = 0;
    logic [3:0] be_seen = 4'hF;
    always @(negedge sram_we_n) we_pulses++;
    always @(negedge clk) if (!sram_we_n) begin
        we_low_cyc++;
        be_seen = sram_be_n;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic bus_floating();
        return (sram_data === 32'hzzzz_zzzz) || (sram_data === 32'h0);
    endfunction

    // Wait at negedges for IDLE (strobes released, no success pulse).
    task automatic wait_idle(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sram_ce_n && !bus.success_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " idle"}, 32'(seen), 32'd1);
    endtask

    // Issue a data op from IDLE, scramble inputs after acceptance, wait for DONE.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [19:0] a,
                          input logic [1:0] b, input logic [31:0] d);
        logic seen;
        wait_idle(tag);
        bus.ramOp_i     = op;
        bus.dataAddr_i  = a;
        bus.bytes_i     = b;
        bus.storeData_i = d;
        @(negedge clk);
        chk({tag, " stall"}, 32'(bus.stall_o), 32'd1);
        bus.dataAddr_i  = 20'h0003F;
        bus.bytes_i     = ~b;
        bus.storeData_i = ~d;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.success_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " done"}, 32'(seen), 32'd1);
        chk({tag, " done_stall"}, 32'(bus.stall_o), 32'd0);
        bus.ramOp_i = MEM_NOP;
        @(negedge clk);
        chk({tag, " one_pulse"}, 32'(bus.success_o), 32'd0);
    endtask

    int   p0;
    int   l0;
    logic ok;

    initial begin
        bus.ramOp_i     = MEM_NOP;
        bus.dataAddr_i  = 20'h0;
        bus.instAddr_i  = 20'h00004;
        bus.storeData_i = 32'h0;
        bus.bytes_i     = 2'd0;
        repeat (3) @(negedge clk);

        chk("rst load_data", bus.load_data_o, 32'h0);
        chk("rst load_inst", bus.load_inst_o, 32'h0);
        chk("rst success", 32'(bus.success_o), 32'd0);
        chk("rst stall", 32'(bus.stall_o), 32'd0);
        chk("rst ce_n", 32'(sram_ce_n), 32'd1);
        chk("rst oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst we_n", 32'(sram_we_n), 32'd1);
        chk("rst be_n", 32'(sram_be_n), 32'hF);
        chk("rst addr", 32'(sram_addr), 32'h0);
        chk("rst bus_z", 32'(bus_floating()), 32'd1);

        // NOP stream: fetch of word 4, result two cycles after FETCH entry.
        rst = 1'b0;
        @(negedge clk);
        chk("fetch entry oe_n", 32'(sram_oe_n), 32'd0);
        chk("fetch entry addr", 32'(sram_addr), 32'h4);
        chk("fetch entry stall", 32'(bus.stall_o), 32'd0);
        @(negedge clk);
        chk("fetch early", bus.load_inst_o, 32'h0);
        @(negedge clk);
        chk("fetch inst", bus.load_inst_o, 32'h2402_0001);
        chk("fetch stall", 32'(bus.stall_o), 32'd0);

        // SW then LW.
        p0 = we_pulses; l0 = we_low_cyc;
        run_op("sw", MEM_SW, 20'h00010, 2'd0, 32'hDEAD_BEEF);
        chk("sw we_pulses", 32'(we_pulses - p0), 32'd1);
        chk("sw we_low", 32'(we_low_cyc - l0), 32'd1);
        chk("sw be_n", 32'(be_seen), 32'h0);
        chk("sw mem", mem[16], 32'hDEAD_BEEF);
        run_op("lw", MEM_LW, 20'h00010, 2'd0, 32'h0);
        chk("lw data", bus.load_data_o, 32'hDEAD_BEEF);

        // SB byte 2, then signed/unsigned byte loads.
        run_op("sb5a", MEM_SB, 20'h00020, 2'd2, 32'hFFFF_FF5A);
        chk("sb5a be_n", 32'(be_seen), 32'hB);
        chk("sb5a mem", mem[32], 32'h115A_3344);
        run_op("lb5a", MEM_LB, 20'h00020, 2'd2, 32'h0);
        chk("lb5a data", bus.load_data_o, 32'h0000_005A);
        run_op("lbu5a", MEM_LBU, 20'h00020, 2'd2, 32'h0);
        chk("lbu5a data", bus.load_data_o, 32'h0000_005A);
        run_op("sba5", MEM_SB, 20'h00020, 2'd2, 32'h0000_00A5);
        chk("sba5 mem", mem[32], 32'h11A5_3344);
        run_op("lba5", MEM_LB, 20'h00020, 2'd2, 32'h0);
        chk("lba5 data", bus.load_data_o, 32'hFFFF_FFA5);
        run_op("lbua5", MEM_LBU, 20'h00020, 2'd2, 32'h0);
        chk("lbua5 data", bus.load_data_o, 32'h0000_00A5);
        run_op("lb0", MEM_LB, 20'h00020, 2'd0, 32'h0);
        chk("lb0 data", bus.load_data_o, 32'h0000_0044);

        // SH upper half, then halfword loads (b[0] ignored).
        run_op("sh", MEM_SH, 20'h00021, 2'd2, 32'hABCD_8001);
        chk("sh be_n", 32'(be_seen), 32'h3);
        chk("sh mem", mem[33], 32'h8001_0000);
        run_op("lh", MEM_LH, 20'h00021, 2'd2, 32'h0);
        chk("lh data", bus.load_data_o, 32'hFFFF_8001);
        run_op("lhu", MEM_LHU, 20'h00021, 2'd2, 32'h0);
        chk("lhu data", bus.load_data_o, 32'h0000_8001);
        run_op("lh3", MEM_LH, 20'h00021, 2'd3, 32'h0);
        chk("lh3 data", bus.load_data_o, 32'hFFFF_8001);
        run_op("lhu0", MEM_LHU, 20'h00021, 2'd0, 32'h0);
        chk("lhu0 data", bus.load_data_o, 32'h0000_0000);

        // Load arriving mid-fetch: fetch completes, stall held until DONE.
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sram_oe_n && !bus.stall_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("midfetch found", 32'(ok), 32'd1);
        bus.ramOp_i    = MEM_LW;
        bus.dataAddr_i = 20'h00010;
        bus.bytes_i    = 2'd0;
        #1;
        chk("midfetch stall", 32'(bus.stall_o), 32'd1);
        ok = 1'b1;
        p0 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.success_o) begin
                p0 = 1;
                break;
            end
            if (!bus.stall_o) ok = 1'b0;
        end
        chk("midfetch done", 32'(p0), 32'd1);
        chk("midfetch stall_held", 32'(ok), 32'd1);
        chk("midfetch done_stall", 32'(bus.stall_o), 32'd0);
        chk("midfetch data", bus.load_data_o, 32'hDEAD_BEEF);
        chk("midfetch inst", bus.load_inst_o, 32'h2402_0001);
        bus.ramOp_i = MEM_NOP;
        @(negedge clk);

        // Reset during the write pulse.
        wait_idle("rstwr");
        bus.ramOp_i     = MEM_SW;
        bus.dataAddr_i  = 20'h00030;
        bus.bytes_i     = 2'd0;
        bus.storeData_i = 32'h1234_5678;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!sram_we_n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rstwr pulse", 32'(ok), 32'd1);
        rst = 1'b1;
        bus.ramOp_i = MEM_NOP;
        @(negedge clk);
        chk("rstwr we_n", 32'(sram_we_n), 32'd1);
        chk("rstwr bus_z", 32'(bus_floating()), 32'd1);
        chk("rstwr stall", 32'(bus.stall_o), 32'd0);
        chk("rstwr success", 32'(bus.success_o), 32'd0);
        chk("rstwr load_data", bus.load_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("lw2", MEM_LW, 20'h00010, 2'd0, 32'h0);
        chk("lw2 data", bus.load_data_o, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
